// File: rtl/prog_loader.sv
// prog_loader: byte-stream command decoder that loads imem words, preloads registers and releases the core.
// Optional idle-timeout abort when PROG_LOADER_TIMEOUT_EN is defined.
module prog_loader #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       i_byte,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_imem_we,
  output logic [31:0]      o_imem_addr,
  output logic [31:0]      o_imem_data,
  output logic             o_reg_we,
  output logic [4:0]       o_reg_addr,
  output logic [31:0]      o_reg_data,
  output logic [31:0]      o_pc_start_addr,
  output logic             o_pc_load,
  output logic             o_core_hold,
  output logic             o_busy,
  output logic             o_err,
  output logic [CNT_W-1:0] o_words_loaded
);
  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_COUNT, S_DATA, S_WR_IMEM,
    S_REG_IDX, S_REG_DATA, S_WR_REG, S_RUN_ADDR, S_GO
  } state_t;
  state_t r_state, w_next;
  logic [1:0]       r_bcnt;
  logic [31:0]      r_sh, r_waddr;
  logic [CNT_W-1:0] r_rem;
  logic [4:0]       r_idx;
  logic             w_acc, w_b3, w_to;
  logic [31:0]      w_word;
  logic [CNT_W-1:0] w_cnt;
  assign o_ready   = !(r_state inside {S_WR_IMEM, S_WR_REG, S_GO});
  assign w_acc     = i_valid && o_ready;
  assign w_b3      = r_bcnt == 2'd3;
  // Fields arrive LSB first, so shifting in from the top leaves the LE value in place.
  assign w_word    = {i_byte, r_sh[31:8]};
  assign w_cnt     = CNT_W'({i_byte, r_sh[31:24]});
  assign o_imem_we = r_state == S_WR_IMEM;
  assign o_reg_we  = r_state == S_WR_REG;
  assign o_pc_load = r_state == S_GO;
  assign o_busy    = r_state != S_IDLE;
`ifdef PROG_LOADER_TIMEOUT_EN
  logic [31:0] r_to;
  logic        w_wait;
  assign w_wait = r_state inside {S_ADDR, S_COUNT, S_DATA, S_REG_IDX, S_REG_DATA, S_RUN_ADDR};
  assign w_to   = w_wait && !w_acc && r_to == 32'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_to <= '0;
    else        r_to <= (w_acc || !w_wait || w_to) ? '0 : r_to + 32'd1;
`else
  localparam int unused_to = TIMEOUT_CYCLES;
  assign w_to = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_acc) w_next = i_byte == 8'h01 ? S_ADDR :
                                      i_byte == 8'h02 ? S_REG_IDX :
                                      i_byte == 8'h03 ? S_RUN_ADDR : S_IDLE;
      S_ADDR:     if (w_acc && w_b3) w_next = S_COUNT;
      S_COUNT:    if (w_acc && r_bcnt[0]) w_next = w_cnt == '0 ? S_IDLE : S_DATA;
      S_DATA:     if (w_acc && w_b3) w_next = S_WR_IMEM;
      S_WR_IMEM:  w_next = r_rem == CNT_W'(1) ? S_IDLE : S_DATA;
      S_REG_IDX:  if (w_acc) w_next = S_REG_DATA;
      S_REG_DATA: if (w_acc && w_b3) w_next = S_WR_REG;
      S_WR_REG:   w_next = S_IDLE;
      S_RUN_ADDR: if (w_acc && w_b3) w_next = S_GO;
      S_GO:       w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
    if (w_to) w_next = S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_bcnt          <= '0;
      r_sh            <= '0;
      r_waddr         <= '0;
      r_rem           <= '0;
      r_idx           <= '0;
      o_imem_addr     <= '0;
      o_imem_data     <= '0;
      o_reg_addr      <= '0;
      o_reg_data      <= '0;
      o_pc_start_addr <= '0;
      o_core_hold     <= 1'b1;
      o_err           <= 1'b0;
      o_words_loaded  <= '0;
    end else begin
      if (w_acc) r_sh <= w_word;
      r_bcnt <= (w_next != r_state || r_state == S_IDLE) ? 2'd0 : w_acc ? r_bcnt + 2'd1 : r_bcnt;
      if (r_state == S_IDLE && w_acc) begin
        if (i_byte == 8'h01 || i_byte == 8'h02) o_core_hold <= 1'b1;
        if (!(i_byte inside {8'h01, 8'h02, 8'h03})) o_err <= 1'b1;
      end
      if (r_state == S_ADDR && w_acc && w_b3) r_waddr <= w_word;
      if (r_state == S_COUNT && w_acc && r_bcnt[0]) r_rem <= w_cnt;
      if (r_state == S_DATA && w_acc && w_b3) begin
        o_imem_addr <= r_waddr;
        o_imem_data <= w_word;
      end
      if (r_state == S_WR_IMEM) begin
        r_waddr        <= r_waddr + 32'd4;
        r_rem          <= r_rem - CNT_W'(1);
        o_words_loaded <= o_words_loaded + CNT_W'(1);
      end
      if (r_state == S_REG_IDX && w_acc) r_idx <= i_byte[4:0];
      if (r_state == S_REG_DATA && w_acc && w_b3) begin
        o_reg_addr <= r_idx;
        o_reg_data <= w_word;
      end
      // Hold drops together with the GO state so pc_load and release coincide.
      if (r_state == S_RUN_ADDR && w_acc && w_b3) begin
        o_pc_start_addr <= w_word;
        o_core_hold     <= 1'b0;
      end
      if (w_to) o_err <= 1'b1;
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: table-driven packet vectors plus hand sequences for latency, idle gaps and mid-packet reset.
module tb_prog_loader;
  logic        clk = 0, rst_n = 0, i_valid = 0;
  logic [7:0]  i_byte = 0;
  logic        o_ready, o_imem_we, o_reg_we, o_pc_load, o_core_hold, o_busy, o_err;
  logic [31:0] o_imem_addr, o_imem_data, o_reg_data, o_pc_start_addr;
  logic [4:0]  o_reg_addr;
  logic [15:0] o_words_loaded;
  int checks = 0, errors = 0, n_rwe = 0, n_pc = 0;
  logic [31:0] qa[$], qd[$];

  prog_loader #(.TIMEOUT_CYCLES(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_byte(i_byte), .i_valid(i_valid), .o_ready(o_ready),
    .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_data(o_imem_data),
    .o_reg_we(o_reg_we), .o_reg_addr(o_reg_addr), .o_reg_data(o_reg_data),
    .o_pc_start_addr(o_pc_start_addr), .o_pc_load(o_pc_load), .o_core_hold(o_core_hold),
    .o_busy(o_busy), .o_err(o_err), .o_words_loaded(o_words_loaded));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] pkt;
    int           len;
    int           n_we;
    logic [31:0]  a0, d0, a1, d1;
    int           n_rwe;
    logic [4:0]   ra;
    logic [31:0]  rd;
    int           n_pc;
    logic [31:0]  pc;
    logic         hold, err;
    logic [15:0]  words;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    @(negedge clk);
    while (!o_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) begin
      errors++;
      $display("FAIL ready_timeout: o_ready stuck at 0 for byte %h", b);
    end else begin
      i_byte  = b;
      i_valid = 1;
      @(negedge clk);
      i_valid = 0;
    end
  endtask

  task automatic send_pkt(input logic [127:0] p, input int len);
    for (int k = 0; k < len; k++) send_byte(p[8*k +: 8]);
  endtask

  always @(negedge clk) begin
    if (o_imem_we) begin
      qa.push_back(o_imem_addr);
      qd.push_back(o_imem_data);
    end
    if (o_reg_we) n_rwe++;
    if (o_pc_load) begin
      n_pc++;
      chk("hold_low_on_pc_load", {31'd0, o_core_hold}, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bw, br, bp;
    tbl[0] = '{128'({32'hB3, 32'h13, 16'd2, 32'h100, 8'h01}), 15, 2, 32'h100, 32'h13, 32'h104, 32'hB3,
               0, 5'd0, 32'h0, 0, 32'h0, 1'b1, 1'b0, 16'd2};
    tbl[1] = '{128'({32'hDEADBEEF, 8'h25, 8'h02}), 6, 0, 0, 0, 0, 0,
               1, 5'd5, 32'hDEADBEEF, 0, 32'h0, 1'b1, 1'b0, 16'd2};
    tbl[2] = '{128'({32'h100, 8'h03}), 5, 0, 0, 0, 0, 0,
               0, 5'd5, 32'hDEADBEEF, 1, 32'h100, 1'b0, 1'b0, 16'd2};
    tbl[3] = '{128'({16'd0, 32'h0, 8'h01}), 7, 0, 0, 0, 0, 0,
               0, 5'd5, 32'hDEADBEEF, 0, 32'h100, 1'b1, 1'b0, 16'd2};
    tbl[4] = '{128'({32'h88776655, 32'h44332211, 16'd2, 32'hFFFFFFFC, 8'h01}), 15, 2,
               32'hFFFFFFFC, 32'h44332211, 32'h0, 32'h88776655,
               0, 5'd5, 32'hDEADBEEF, 0, 32'h100, 1'b1, 1'b0, 16'd4};
    tbl[5] = '{128'(8'h7F), 1, 0, 0, 0, 0, 0,
               0, 5'd5, 32'hDEADBEEF, 0, 32'h100, 1'b1, 1'b1, 16'd4};
    tbl[6] = '{128'({32'h12345678, 8'h03}), 5, 0, 0, 0, 0, 0,
               0, 5'd5, 32'hDEADBEEF, 1, 32'h12345678, 1'b0, 1'b1, 16'd4};

    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_hold", {31'd0, o_core_hold}, 1);
    chk("rst_ready", {31'd0, o_ready}, 1);
    chk("rst_strobes", {29'd0, o_imem_we, o_reg_we, o_pc_load}, 0);
    chk("rst_busy_err", {30'd0, o_busy, o_err}, 0);
    chk("rst_words", {16'd0, o_words_loaded}, 0);
    chk("rst_pc", o_pc_start_addr, 0);

    for (int v = 0; v < 7; v++) begin
      bw = qa.size(); br = n_rwe; bp = n_pc;
      send_pkt(tbl[v].pkt, tbl[v].len);
      repeat (8) @(negedge clk);
      chk($sformatf("v%0d_n_imem_we", v), qa.size() - bw, tbl[v].n_we);
      if (tbl[v].n_we >= 1 && qa.size() > bw) begin
        chk($sformatf("v%0d_addr0", v), qa[bw], tbl[v].a0);
        chk($sformatf("v%0d_data0", v), qd[bw], tbl[v].d0);
      end
      if (tbl[v].n_we >= 2 && qa.size() > bw + 1) begin
        chk($sformatf("v%0d_addr1", v), qa[bw+1], tbl[v].a1);
        chk($sformatf("v%0d_data1", v), qd[bw+1], tbl[v].d1);
      end
      chk($sformatf("v%0d_n_reg_we", v), n_rwe - br, tbl[v].n_rwe);
      chk($sformatf("v%0d_reg_addr", v), {27'd0, o_reg_addr}, {27'd0, tbl[v].ra});
      chk($sformatf("v%0d_reg_data", v), o_reg_data, tbl[v].rd);
      chk($sformatf("v%0d_n_pc_load", v), n_pc - bp, tbl[v].n_pc);
      chk($sformatf("v%0d_pc_start", v), o_pc_start_addr, tbl[v].pc);
      chk($sformatf("v%0d_hold", v), {31'd0, o_core_hold}, {31'd0, tbl[v].hold});
      chk($sformatf("v%0d_err", v), {31'd0, o_err}, {31'd0, tbl[v].err});
      chk($sformatf("v%0d_words", v), {16'd0, o_words_loaded}, {16'd0, tbl[v].words});
      chk($sformatf("v%0d_busy", v), {31'd0, o_busy}, 0);
    end

    // Hold re-asserts the cycle after a LOAD command byte while the core runs.
    send_byte(8'h02);
    chk("hold_after_load_cmd", {31'd0, o_core_hold}, 1);
    chk("busy_in_packet", {31'd0, o_busy}, 1);
    send_pkt(128'({32'h11223344, 8'h03}), 5);
    repeat (3) @(negedge clk);
    chk("reg2_addr", {27'd0, o_reg_addr}, 3);
    chk("reg2_data", o_reg_data, 32'h11223344);

    // Strobe lands exactly one cycle after the 4th data byte and lasts one cycle.
    send_pkt(128'({24'hC3B2A1, 16'd1, 32'h10, 8'h01}), 10);
    send_byte(8'hD4);
    chk("lat_we", {31'd0, o_imem_we}, 1);
    chk("lat_addr", o_imem_addr, 32'h10);
    chk("lat_data", o_imem_data, 32'hD4C3B2A1);
    @(negedge clk);
    chk("lat_we_one_cycle", {31'd0, o_imem_we}, 0);
    chk("lat_idle", {31'd0, o_busy}, 0);
    chk("lat_words", {16'd0, o_words_loaded}, 5);

    // Idle gap mid-packet.
    bw = qa.size();
    send_pkt(128'({8'hAA, 8'h01}), 2);
    repeat (20) @(negedge clk);
`ifdef PROG_LOADER_TIMEOUT_EN
    chk("gap_aborted_idle", {31'd0, o_busy}, 0);
    chk("gap_err", {31'd0, o_err}, 1);
    chk("gap_no_strobe", qa.size() - bw, 0);
    chk("gap_hold", {31'd0, o_core_hold}, 1);
`else
    chk("gap_still_busy", {31'd0, o_busy}, 1);
    send_pkt(128'({32'hAABBCCDD, 16'd1, 24'h0}), 9);
    repeat (4) @(negedge clk);
    chk("gap_n_we", qa.size() - bw, 1);
    if (qa.size() > bw) begin
      chk("gap_addr", qa[bw], 32'hAA);
      chk("gap_data", qd[bw], 32'hAABBCCDD);
    end
    chk("gap_words", {16'd0, o_words_loaded}, 6);
`endif

    // Reset mid-DATA discards the partial word.
    send_pkt(128'({16'hBBAA, 16'd1, 32'h200, 8'h01}), 9);
    bw = qa.size();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (5) @(negedge clk);
    chk("midrst_no_strobe", qa.size() - bw, 0);
    chk("midrst_idle", {31'd0, o_busy}, 0);
    chk("midrst_hold", {31'd0, o_core_hold}, 1);
    chk("midrst_err", {31'd0, o_err}, 0);
    chk("midrst_words", {16'd0, o_words_loaded}, 0);
    chk("midrst_ready", {31'd0, o_ready}, 1);
    send_pkt(128'({32'h04030201, 16'd1, 32'h0, 8'h01}), 11);
    repeat (4) @(negedge clk);
    chk("post_rst_n_we", qa.size() - bw, 1);
    if (qa.size() > bw) begin
      chk("post_rst_addr", qa[bw], 32'h0);
      chk("post_rst_data", qd[bw], 32'h04030201);
    end
    chk("post_rst_words", {16'd0, o_words_loaded}, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Host-side initiator for the core's external load interface.
- Consumes a byte stream (valid/ready) from a host link (UART RX, JTAG bridge, or testbench).
- Decodes simple command packets. Writes little-endian 32-bit words into instruction memory, preloads register-file entries, and releases the core at a chosen start PC.
- Holds the core stalled from reset until a RUN command completes.

Parameters:
- TIMEOUT_CYCLES, 65535, idle cycles allowed between bytes of one packet before abort (used only with the optional feature).
- CNT_W, 16, width of the word-count field and of o_words_loaded.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_byte  in  8  stream data byte
- i_valid  in  1  i_byte valid
- o_ready  out  1  loader accepts i_byte this cycle
- o_imem_we  out  1  instruction-memory write strobe, one cycle per word
- o_imem_addr  out  32  byte address of word being written
- o_imem_data  out  32  assembled word
- o_reg_we  out  1  register preload strobe, one cycle
- o_reg_addr  out  5  register index
- o_reg_data  out  32  register value
- o_pc_start_addr  out  32  core start PC
- o_pc_load  out  1  one-cycle pulse: PC loads o_pc_start_addr
- o_core_hold  out  1  core stall/ctrl-override (1 = core frozen, load muxes select loader)
- o_busy  out  1  packet in progress (state != IDLE)
- o_err  out  1  sticky error flag
- o_words_loaded  out  CNT_W  words written since reset (wraps)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; o_core_hold=1; every other output 0; o_pc_start_addr=0. Reset mid-packet discards the partial packet, and no strobe is issued.
- Byte transfer occurs when i_valid && o_ready. Multi-byte fields are little-endian (first byte = bits 7:0).
- o_ready=1 in IDLE, ADDR, COUNT, DATA, REG_IDX, REG_DATA, RUN_ADDR. o_ready=0 in WR_IMEM, WR_REG, GO.
- Commands, decoded in IDLE:
  - 0x01 LOAD_IMEM: 4B start address, 2B word count N, then 4N data bytes.
  - 0x02 LOAD_REG: 1B index (bits 4:0 used, 7:5 ignored), then 4B value.
  - 0x03 RUN: 4B start address.
  - Any other byte: set o_err, stay in IDLE, consume the byte.
- FSM:
  - IDLE -> ADDR | REG_IDX | RUN_ADDR by command. A LOAD command sets o_core_hold=1 on the cycle after the command byte.
  - ADDR (4 bytes) -> COUNT (2 bytes).
  - COUNT: N==0 -> IDLE. Otherwise -> DATA.
  - DATA: after the 4th byte of a word -> WR_IMEM.
  - WR_IMEM (1 cycle): o_imem_we=1 with stable addr/data. o_words_loaded++. Address += 4, wrapping mod 2^32. Remaining count--. If remaining==0 -> IDLE, else -> DATA.
  - REG_IDX (1 byte) -> REG_DATA (4 bytes) -> WR_REG. WR_REG (1 cycle): o_reg_we=1. Writes to index 0 are still strobed; x0 protection is the register file's job. -> IDLE.
  - RUN_ADDR (4 bytes) -> GO. GO (1 cycle): o_pc_start_addr latched, o_pc_load=1, o_core_hold=0. -> IDLE.
- Write latency: the WR_IMEM strobe occurs exactly 1 cycle after the accepting edge of the word's 4th byte. Max throughput is 1 word per 5 cycles.
- o_imem_addr, o_imem_data, o_reg_* hold their last values outside strobe cycles.
- i_valid=0 mid-packet: the FSM simply waits, with no timeout unless the optional feature is enabled.
- RUN while the core is already running: re-pulses o_pc_load (restart); o_core_hold stays 0.
- o_err clears only on reset.

Optional Feature:
- Macro: PROG_LOADER_TIMEOUT_EN.
- Defined: a counter resets on every accepted byte and counts cycles while state is not in {IDLE, WR_IMEM, WR_REG, GO}. When it reaches TIMEOUT_CYCLES: return to IDLE, set o_err, issue no strobe. Words already written remain written, and o_core_hold stays 1.
- Undefined: no counter logic; the FSM waits indefinitely.

Test Plan:
- Reset -> o_core_hold=1, o_ready=1, all strobes 0, o_words_loaded=0. Assert rst_n=0 mid-DATA -> state IDLE, no o_imem_we.
- Stream 01 00 01 00 00 02 00 13 00 00 00 B3 00 00 00 -> two o_imem_we pulses: (0x00000100, 0x00000013) then (0x00000104, 0x000000B3); o_words_loaded=2.
- Stream 02 25 EF BE AD DE -> one o_reg_we with o_reg_addr=5, o_reg_data=0xDEADBEEF.
- Stream 03 00 01 00 00 -> one-cycle o_pc_load with o_pc_start_addr=0x00000100; o_core_hold falls the same cycle. A following 01 command -> hold returns to 1.
- LOAD_IMEM at 0xFFFFFFFC with N=2 -> writes at 0xFFFFFFFC then 0x00000000. LOAD_IMEM with N=0 -> no strobe, back to IDLE. Command 0x7F -> o_err=1, next valid command still works.
- With PROG_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=16: send 01 AA, then idle 16 cycles -> o_err=1, IDLE, no strobe. Without the macro, the same idle period -> still waiting, and the packet completes normally.
